dcache_wb: RTL and testbench
============================

Name: dcache_wb

Overview:
Parametrised direct-mapped, write-back, write-allocate data cache between the core's load/store stage and a word-wide backing memory port. It replaces the flat single-cycle data memory. It adds a valid/ready request handshake, byte-lane stores with alignment checking, line refill and dirty-line writeback over a beat handshake, and asynchronous active-low reset of all tag state.

Parameters:
ADDR_WIDTH, 32, byte address width
LINE_WORDS, 4, 32-bit words per line; power of two, >=2
NUM_LINES, 64, lines in cache; power of two
- Derived: OFF=log2(LINE_WORDS)+2, IDX=log2(NUM_LINES), TAG=ADDR_WIDTH-IDX-OFF

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  core request present
req_ready  out  1  cache accepts request this cycle
req_addr  in  ADDR_WIDTH  byte address
req_write_data  in  32  store data, lane-aligned to the low bits (byte in [7:0], half in [15:0])
req_write_width  in  2  0=load, 1=byte store, 2=half store, 3=word store
resp_valid  out  1  one-cycle response pulse
resp_read_data  out  32  aligned word containing req_addr (loads); 0 for stores
resp_err  out  1  misaligned access, qualified by resp_valid
mem_req  out  1  backing-memory beat request
mem_we  out  1  1=write beat, 0=read beat
mem_addr  out  ADDR_WIDTH  word-aligned beat address
mem_wdata  out  32  writeback data
mem_ack  in  1  beat complete; mem_rdata valid this cycle for reads
mem_rdata  in  32  refill data

Behaviour:
- Reset (reset_n low, async): all valid and dirty bits = 0; state=IDLE; req_ready=0 while asserted, then 1 in IDLE; resp_valid=0, resp_err=0, resp_read_data=0; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0. Data and tag arrays are not reset.
- Reset mid-operation: any in-flight beat or request is abandoned; mem_req drops immediately; no response is ever issued for it.
- Handshake: a request is accepted when req_valid && req_ready; req_ready=1 only in IDLE. Addr, data and width are registered on accept. Exactly one resp_valid pulse per accepted request.
- Address split: offset [OFF-1:0], word-in-line [OFF-1:2], index [OFF+IDX-1:OFF], tag [ADDR_WIDTH-1:OFF+IDX].
- States:
  - IDLE -> LOOKUP on accept.
  - LOOKUP, misaligned (half with addr[0]=1; word with addr[1:0]!=0): resp_valid=1, resp_err=1. No array update, no memory traffic. -> IDLE.
  - LOOKUP, hit (valid && tag match): resp_valid=1. Load returns the stored word. Store merges only the enabled lanes (byte at addr[1:0], half at addr[1]) and sets dirty. -> IDLE. Hit latency: accept at cycle N, resp_valid at N+1.
  - LOOKUP, miss with victim valid && dirty -> WB. Otherwise -> REFILL.
  - WB: LINE_WORDS write beats at victim address (old tag, index, word 0..LINE_WORDS-1, ascending). Advance on mem_ack. After the last ack: dirty=0 -> REFILL.
  - REFILL: LINE_WORDS read beats, ascending, each mem_rdata written on mem_ack. After the last ack: tag written, valid=1, dirty=0 -> LOOKUP, which now hits and completes the request.
- Beat rule: mem_req, mem_we, mem_addr and mem_wdata are held stable from assertion until the cycle mem_ack is sampled high. mem_req may stay high into the next beat with the new address. mem_ack while mem_req=0 is ignored.
- Width 0 with any address is a load; loads are never misaligned.
- Counters wrap at LINE_WORDS-1. The last-beat detect uses counter==LINE_WORDS-1 && mem_ack.

Test Plan:
- Cold load 0x0000_0100 with memory word = addr: 4 read beats at 0x100, 0x104, 0x108, 0x10C, no write beats -> resp_read_data=0x0000_0100, resp_err=0.
- Byte store 0xAB to 0x102 after a line hit on word 0xDEADBEEF -> next load of 0x100 returns 0xDEABBEEF, zero memory beats, resp 1 cycle after accept.
- Dirty eviction: store to 0x100, then load 0x0000_0500 (same index, different tag) -> 4 write beats at 0x100..0x10C carrying the modified line, then 4 read beats at 0x500..0x50C.
- Half store to 0x101 -> resp_err=1, no mem_req, later load of 0x100 unchanged.
- mem_ack delayed 3 cycles per beat -> mem_addr/mem_wdata held constant throughout, each beat still counted once.
- reset_n pulsed low during refill beat 2 -> mem_req=0 asynchronously, no resp_valid; load 0x100 afterward misses and performs a full 4-beat refill.

Source files
------------

// File: rtl/dcache_wb_if.sv
// ---------------------------------------------------------------------------
// dcache_wb_if.sv
// Bus bundles for the write-back data cache.
//
// dcache_core_if : load/store stage <-> cache.
//   master (core side)  drives req_valid, req_addr, req_write_data,
//                       req_write_width; receives req_ready, resp_valid,
//                       resp_read_data, resp_err.
//   slave  (cache side) is the mirror image.
//
// dcache_mem_if : cache <-> word-wide backing memory.
//   master (cache side) drives mem_req, mem_we, mem_addr, mem_wdata;
//                       receives mem_ack, mem_rdata.
//   slave  (memory side) is the mirror image.
//
// Handshake semantics:
//   Request : a transfer happens on a rising edge where req_valid && req_ready.
//             req_ready is only offered while the cache is idle. Every
//             accepted request gets exactly one single-cycle resp_valid pulse.
//   Memory  : a beat is offered while mem_req is high. mem_we, mem_addr and
//             mem_wdata stay constant until the edge where mem_ack is sampled
//             high; that edge completes the beat (mem_rdata is valid in that
//             cycle for reads). mem_req may stay high into the next beat with
//             a new address. mem_ack while mem_req is low has no effect.
// ---------------------------------------------------------------------------
interface dcache_core_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_write_data;
    logic [1:0]            req_write_width;
    logic                  resp_valid;
    logic [31:0]           resp_read_data;
    logic                  resp_err;

    modport master (
        output req_valid, req_addr, req_write_data, req_write_width,
        input  req_ready, resp_valid, resp_read_data, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_write_data, req_write_width,
        output req_ready, resp_valid, resp_read_data, resp_err
    );
endinterface

interface dcache_mem_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  mem_ack;
    logic [31:0]           mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/dcache_wb.sv
// ---------------------------------------------------------------------------
// dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache.
//
// Ports:
//   clk        : clock, all state on rising edge
//   reset_n    : asynchronous active-low reset (valid/dirty bits, FSM, regs)
//   core       : dcache_core_if.slave  - load/store request and response
//   mem        : dcache_mem_if.master  - backing memory beat port
//   state_dbg  : current FSM state (0=IDLE 1=LOOKUP 2=WB 3=REFILL)
//
// Address split: tag | index | word-in-line | byte offset.
// A request is registered on accept and resolved in LOOKUP. A miss first
// writes back a dirty victim (WB), then refills the line (REFILL) and returns
// to LOOKUP, where the request now hits and completes.
// ---------------------------------------------------------------------------
module dcache_wb #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 64
) (
    input  logic          clk,
    input  logic          reset_n,
    dcache_core_if.slave  core,
    dcache_mem_if.master  mem,
    output logic [1:0]    state_dbg
);
    localparam int WW  = $clog2(LINE_WORDS);
    localparam int OFF = WW + 2;
    localparam int IDX = $clog2(NUM_LINES);
    localparam int TAG = ADDR_WIDTH - IDX - OFF;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_WB     = 2'd2,
        S_REFILL = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Registered request
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [1:0]            width_q;

    // Line state: valid/dirty are reset, tag/data arrays are not
    logic [NUM_LINES-1:0]  valid_q;
    logic [NUM_LINES-1:0]  dirty_q;
    logic [TAG-1:0]        tag_mem  [NUM_LINES];
    logic [31:0]           data_mem [NUM_LINES*LINE_WORDS];

    // Beat counter shared by WB and REFILL; wraps to 0 after the last beat,
    // so REFILL always starts at word 0 right after a writeback.
    logic [WW-1:0]         beat_q;

    logic [TAG-1:0]        req_tag;
    logic [IDX-1:0]        req_idx;
    logic [WW-1:0]         req_word;
    logic [TAG-1:0]        line_tag;
    logic                  line_valid;
    logic                  line_dirty;
    logic                  hit;
    logic                  misaligned;
    logic                  is_store;
    logic                  accept;
    logic                  beat_ack;
    logic                  last_beat;
    logic [31:0]           line_word;
    logic [31:0]           beat_word;
    logic [31:0]           lane_mask;
    logic [31:0]           lane_data;
    logic [31:0]           merged_word;

    assign req_tag    = addr_q[ADDR_WIDTH-1 -: TAG];
    assign req_idx    = addr_q[OFF +: IDX];
    assign req_word   = addr_q[2 +: WW];
    assign line_tag   = tag_mem[req_idx];
    assign line_valid = valid_q[req_idx];
    assign line_dirty = dirty_q[req_idx];
    assign hit        = line_valid && (line_tag == req_tag);
    assign is_store   = (width_q != 2'd0);
    assign misaligned = ((width_q == 2'd2) && addr_q[0]) ||
                        ((width_q == 2'd3) && (addr_q[1:0] != 2'b00));
    assign accept     = core.req_valid && core.req_ready;
    // Only acks that complete an offered beat count.
    assign beat_ack   = mem.mem_ack && ((state == S_WB) || (state == S_REFILL));
    assign last_beat  = beat_ack && (beat_q == WW'(LINE_WORDS - 1));
    assign line_word  = data_mem[{req_idx, req_word}];
    assign beat_word  = data_mem[{req_idx, beat_q}];

    // Store lane selection: store data arrives in the low bits and is
    // replicated so that the mask alone picks the target lane.
    always_comb begin
        lane_mask = 32'h0000_0000;
        lane_data = wdata_q;
        case (width_q)
            2'd1: begin
                lane_mask = 32'h0000_00FF << {addr_q[1:0], 3'b000};
                lane_data = {4{wdata_q[7:0]}};
            end
            2'd2: begin
                lane_mask = addr_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                lane_data = {2{wdata_q[15:0]}};
            end
            2'd3: begin
                lane_mask = 32'hFFFF_FFFF;
                lane_data = wdata_q;
            end
            default: begin
                lane_mask = 32'h0000_0000;
                lane_data = wdata_q;
            end
        endcase
        merged_word = (line_word & ~lane_mask) | (lane_data & lane_mask);
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (misaligned || hit)           state_nxt = S_IDLE;
                else if (line_valid && line_dirty) state_nxt = S_WB;
                else                             state_nxt = S_REFILL;
            end
            S_WB: begin
                if (last_beat) state_nxt = S_REFILL;
            end
            S_REFILL: begin
                if (last_beat) state_nxt = S_LOOKUP;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Memory outputs are decoded from state/counter, so an asynchronous reset
    // drops mem_req at once and the beat fields cannot move until the ack.
    always_comb begin
        core.req_ready      = reset_n && (state == S_IDLE);
        core.resp_valid     = 1'b0;
        core.resp_err       = 1'b0;
        core.resp_read_data = 32'h0000_0000;
        mem.mem_req         = 1'b0;
        mem.mem_we          = 1'b0;
        mem.mem_addr        = '0;
        mem.mem_wdata       = 32'h0000_0000;
        case (state)
            S_LOOKUP: begin
                if (misaligned) begin
                    core.resp_valid = 1'b1;
                    core.resp_err   = 1'b1;
                end else if (hit) begin
                    core.resp_valid     = 1'b1;
                    core.resp_read_data = is_store ? 32'h0000_0000 : line_word;
                end
            end
            S_WB: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_addr  = {line_tag, req_idx, beat_q, 2'b00};
                mem.mem_wdata = beat_word;
            end
            S_REFILL: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = {req_tag, req_idx, beat_q, 2'b00};
            end
            default: ;
        endcase
        state_dbg = state;
    end

    // ---------------- request registers, line state, beat counter ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            wdata_q <= 32'h0000_0000;
            width_q <= 2'd0;
            valid_q <= '0;
            dirty_q <= '0;
            beat_q  <= '0;
        end else begin
            if (accept) begin
                addr_q  <= core.req_addr;
                wdata_q <= core.req_write_data;
                width_q <= core.req_write_width;
            end
            if (beat_ack) begin
                beat_q <= beat_q + 1'b1;
            end
            if ((state == S_LOOKUP) && !misaligned && hit && is_store) begin
                dirty_q[req_idx] <= 1'b1;
            end
            if ((state == S_WB) && last_beat) begin
                dirty_q[req_idx] <= 1'b0;
            end
            if ((state == S_REFILL) && last_beat) begin
                valid_q[req_idx] <= 1'b1;
                dirty_q[req_idx] <= 1'b0;
            end
        end
    end

    // ---------------- tag and data arrays ----------------
    always_ff @(posedge clk) begin
        if ((state == S_REFILL) && beat_ack) begin
            data_mem[{req_idx, beat_q}] <= mem.mem_rdata;
        end
        if ((state == S_REFILL) && last_beat) begin
            tag_mem[req_idx] <= req_tag;
        end
        if ((state == S_LOOKUP) && !misaligned && hit && is_store) begin
            data_mem[{req_idx, req_word}] <= merged_word;
        end
    end

endmodule

// File: tb/tb_dcache_wb.sv
// ---------------------------------------------------------------------------
// tb_dcache_wb.sv
// Self-checking bench for dcache_wb. The reference treats the cache as a
// transparent byte-addressed memory (flat_mem) and separately tracks which
// line each index holds, to predict the exact beat sequence of each request.
// A backing-memory responder acks beats with a programmable delay.
// ---------------------------------------------------------------------------
module tb_dcache_wb;
    localparam int AW    = 32;
    localparam int LW    = 4;
    localparam int NL    = 64;
    localparam int OFFB  = $clog2(LW) + 2;
    localparam int TSH   = OFFB + $clog2(NL);

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [1:0] state_dbg;

    always #5 clk = ~clk;

    dcache_core_if #(.ADDR_WIDTH(AW)) core_bus ();
    dcache_mem_if  #(.ADDR_WIDTH(AW)) mem_bus ();

    dcache_wb #(
        .ADDR_WIDTH (AW),
        .LINE_WORDS (LW),
        .NUM_LINES  (NL)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .core      (core_bus.slave),
        .mem       (mem_bus.master),
        .state_dbg (state_dbg)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] flat_mem [int unsigned];   // what the core must see
    logic [31:0] back_mem [int unsigned];   // what the backing memory holds
    bit          m_valid [NL];
    bit          m_dirty [NL];
    int unsigned m_tag   [NL];
    logic [64:0] exp_q [$];                 // {we, addr, wdata}; reads carry 0
    logic [64:0] obs_q [$];

    function automatic logic [31:0] rd_flat(input logic [31:0] a);
        return flat_mem.exists(a) ? flat_mem[a] : a;
    endfunction

    function automatic logic [31:0] rd_back(input logic [31:0] a);
        return back_mem.exists(a) ? back_mem[a] : a;
    endfunction

    // ---------------- backing memory responder ----------------
    int          ack_mode = -1;   // -1: random 0..2 wait cycles, else fixed
    int          dly = 0;
    bit          active = 1'b0;
    logic        beat_we;
    logic [31:0] beat_addr;
    logic [31:0] beat_wdata;

    always @(negedge clk) begin
        mem_bus.mem_ack = 1'b0;
        if (!reset_n || !mem_bus.mem_req) begin
            active = 1'b0;
        end else begin
            if (!active) begin
                active     = 1'b1;
                beat_we    = mem_bus.mem_we;
                beat_addr  = mem_bus.mem_addr;
                beat_wdata = mem_bus.mem_wdata;
                dly        = (ack_mode < 0) ? int'($urandom_range(0, 2)) : ack_mode;
            end else begin
                check("beat_hold", {mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata},
                      {beat_we, beat_addr, beat_wdata});
            end
            if (dly == 0) begin
                mem_bus.mem_ack = 1'b1;
                if (beat_we) begin
                    back_mem[beat_addr] = beat_wdata;
                    obs_q.push_back({1'b1, beat_addr, beat_wdata});
                end else begin
                    mem_bus.mem_rdata = rd_back(beat_addr);
                    obs_q.push_back({1'b0, beat_addr, 32'h0});
                end
                active = 1'b0;
            end else begin
                dly--;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
        logic [31:0] wa;
        logic [31:0] va;
        logic [31:0] cur;
        logic [31:0] exp_rd;
        int unsigned idx;
        int unsigned tag;
        int          sh;
        int          cyc;
        int          lat;
        bit          mis;
        wa     = a & ~32'h3;
        idx    = (a >> OFFB) % NL;
        tag    = a >> TSH;
        mis    = ((w == 2'd2) && a[0]) || ((w == 2'd3) && (a[1:0] != 2'b00));
        exp_rd = 32'h0;
        exp_q.delete();
        obs_q.delete();
        if (!mis) begin
            if (!(m_valid[idx] && m_tag[idx] == tag)) begin
                if (m_valid[idx] && m_dirty[idx]) begin
                    for (int k = 0; k < LW; k++) begin
                        va = (m_tag[idx] << TSH) | (idx << OFFB) | (k * 4);
                        exp_q.push_back({1'b1, va, rd_flat(va)});
                    end
                end
                for (int k = 0; k < LW; k++) begin
                    va = (a & ~32'(LW * 4 - 1)) + k * 4;
                    exp_q.push_back({1'b0, va, 32'h0});
                end
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tag;
                m_dirty[idx] = 1'b0;
            end
            cur = rd_flat(wa);
            if (w == 2'd0) begin
                exp_rd = cur;
            end else begin
                if (w == 2'd1) begin
                    sh  = 8 * a[1:0];
                    cur = (cur & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
                end else if (w == 2'd2) begin
                    sh  = 16 * a[1];
                    cur = (cur & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
                end else begin
                    cur = d;
                end
                flat_mem[wa] = cur;
                m_dirty[idx] = 1'b1;
            end
        end

        @(negedge clk);
        core_bus.req_valid       = 1'b1;
        core_bus.req_addr        = a;
        core_bus.req_write_data  = d;
        core_bus.req_write_width = w;
        cyc = 0;
        while (!core_bus.req_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("accept_timeout", cyc < 50, 1'b1);
        @(negedge clk);
        core_bus.req_valid = 1'b0;
        lat = 1;
        while (!core_bus.resp_valid && lat < 500) begin
            @(negedge clk);
            lat++;
        end
        check("resp_valid", core_bus.resp_valid, 1'b1);
        check("resp_data", core_bus.resp_read_data, exp_rd);
        check("resp_err", core_bus.resp_err, mis);
        if (exp_q.size() == 0) check("hit_latency", lat, 1);
        check("beat_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check("beat", obs_q[i], exp_q[i]);
        end
        @(negedge clk);
        check("single_pulse", core_bus.resp_valid, 1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cyc;
        core_bus.req_valid       = 1'b0;
        core_bus.req_addr        = '0;
        core_bus.req_write_data  = '0;
        core_bus.req_write_width = 2'd0;
        reset_n = 1'b0;
        for (int i = 0; i < NL; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = 0;
        end

        repeat (2) @(negedge clk);
        check("rst_ready", core_bus.req_ready, 1'b0);
        check("rst_resp_valid", core_bus.resp_valid, 1'b0);
        check("rst_resp_err", core_bus.resp_err, 1'b0);
        check("rst_resp_data", core_bus.resp_read_data, 32'h0);
        check("rst_mem_req", mem_bus.mem_req, 1'b0);
        check("rst_mem_we", mem_bus.mem_we, 1'b0);
        check("rst_mem_addr", mem_bus.mem_addr, 32'h0);
        check("rst_mem_wdata", mem_bus.mem_wdata, 32'h0);
        #2 reset_n = 1'b1;
        @(negedge clk);
        check("idle_ready", core_bus.req_ready, 1'b1);

        // Cold load, 4 read beats, data = address
        do_req(32'h0000_0100, 32'h0, 2'd0);
        // Word store then byte-lane store, then hit load
        do_req(32'h0000_0100, 32'hDEAD_BEEF, 2'd3);
        do_req(32'h0000_0102, 32'h0000_00AB, 2'd1);
        do_req(32'h0000_0100, 32'h0, 2'd0);
        check("byte_merge", rd_flat(32'h100), 32'hDEAB_BEEF);
        // Dirty eviction by a same-index, different-tag load
        do_req(32'h0000_0500, 32'h0, 2'd0);
        // Misaligned half store, then line unchanged
        do_req(32'h0000_0101, 32'h0000_1234, 2'd2);
        do_req(32'h0000_0100, 32'h0, 2'd0);
        // Misaligned word stores and an odd-address load (legal)
        do_req(32'h0000_0102, 32'h1111_2222, 2'd3);
        do_req(32'h0000_0103, 32'h0, 2'd0);

        // Slow memory: 3 wait cycles per beat across a dirty eviction
        ack_mode = 3;
        do_req(32'h0000_0104, 32'hCAFE_F00D, 2'd3);
        do_req(32'h0000_0504, 32'h0, 2'd0);

        // Reset in the middle of a refill
        exp_q.delete();
        obs_q.delete();
        @(negedge clk);
        core_bus.req_valid       = 1'b1;
        core_bus.req_addr        = 32'h0000_0140;
        core_bus.req_write_width = 2'd0;
        cyc = 0;
        while (!core_bus.req_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        core_bus.req_valid = 1'b0;
        cyc = 0;
        while (obs_q.size() < 2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("refill_progress", obs_q.size() >= 2, 1'b1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_mem_req", mem_bus.mem_req, 1'b0);
        check("mid_rst_resp", core_bus.resp_valid, 1'b0);
        check("mid_rst_ready", core_bus.req_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_rst_no_resp", core_bus.resp_valid, 1'b0);
        end
        #2 reset_n = 1'b1;
        for (int i = 0; i < NL; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        flat_mem = back_mem;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_no_resp", core_bus.resp_valid, 1'b0);
        end
        ack_mode = -1;
        do_req(32'h0000_0100, 32'h0, 2'd0);
        do_req(32'h0000_0140, 32'h0, 2'd0);

        // Randomized traffic over a few conflicting indices and tags
        for (int n = 0; n < 250; n++) begin
            logic [31:0] ra;
            ra = (32'($urandom_range(0, 3)) << TSH) |
                 (32'($urandom_range(14, 17)) << OFFB) |
                 32'($urandom_range(0, 15));
            do_req(ra, $urandom, 2'($urandom_range(0, 3)));
        end

        // Read back every touched word once
        for (int t = 0; t < 4; t++) begin
            for (int ix = 14; ix <= 17; ix++) begin
                for (int k = 0; k < LW; k++) begin
                    do_req((32'(t) << TSH) | (32'(ix) << OFFB) | 32'(k * 4), 32'h0, 2'd0);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
